sequence_checker: RTL
=====================

Name: sequence_checker

Overview:
- Receive-side counterpart of the 8-entry sequence generator.
- Samples the generator's byte stream when data_valid is high and checks it against the fixed sequence AF, BC, E2, 78, FF, E2, 0B, 8D.
- Reports lock, completed sequences and mismatches.
- Sits at the consuming end of the generator link; used for in-system self-test of the datapath.

Parameters:
- SEQ_LEN, 8, number of entries in the expected sequence; fixed to the package table length.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_valid  input  1  data_in is sampled this cycle.
- data_in  input  8  received sequence byte.
- clear_err  input  1  synchronous clear of err_count.
- locked  output  1  high while state is TRACK.
- exp_index  output  3  index of the next expected byte.
- seq_done  output  1  one-cycle pulse when byte 7 (8D) matches in TRACK.
- seq_error  output  1  one-cycle pulse on any mismatch while in TRACK.
- err_count  output  ERR_CNT_W  saturating count of mismatches.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=HUNT, exp_index=0.
  - locked, seq_done, seq_error = 0; err_count=0.
- All outputs are registered. A response appears on the cycle after the data_valid sample edge.
- data_valid low: state, exp_index and err_count hold; seq_done and seq_error are 0.
- HUNT, valid byte == SEQ[0] (AF): go to TRACK, exp_index=1.
- HUNT, any other valid byte: stay in HUNT, exp_index=0. No error is flagged while hunting.
- TRACK, valid byte == SEQ[exp_index]: exp_index+1 (3-bit wrap 7->0). At exp_index==7, seq_done pulses and the state stays TRACK expecting AF.
- TRACK, mismatch:
  - seq_error pulses and err_count increments.
  - If the byte is AF: stay in TRACK (resync) with exp_index=1.
  - Otherwise: go to HUNT with exp_index=0.
- err_count saturates at all-ones. When clear_err and an increment coincide, clear wins and the result is 0.
- locked = (state==TRACK), registered.
- Duplicate value E2 (indices 2 and 5): the comparison is positional only, with no content-based search.
- Reset mid-sequence: immediate return to the reset values.

Optional Feature:
- Macro SEQ_CHECKER_STATS_EN.
- Defined:
  - Adds output done_count[15:0], incremented on every seq_done and wrapping at FFFF.
  - Cleared by reset and by clear_err.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package seq_pkg holds:
  - SEQ_LEN = 8.
  - The constant table SEQ[0:7] = AF, BC, E2, 78, FF, E2, 0B, 8D.
  - The state enum {HUNT, TRACK}.
- The generator and the checker share this package.
- One sub-module, sat_counter (parameterised width, inc, clr, saturating), is used for err_count.

Test Plan:
- Reset, then 16 consecutive valid bytes forming two full sequences:
  - locked=1 from the cycle after the first AF.
  - seq_done pulses twice, after each 8D.
  - err_count=0.
- Idle bytes 00, 12 then AF BC E2 78 FF E2 0B 8D: no seq_error while hunting, lock after AF, one seq_done.
- Locked, send 00 in place of 78 (index 3): seq_error pulse, err_count=1, locked=0, exp_index=0.
- Locked at exp_index=4, send AF: seq_error pulse, locked stays 1, exp_index=1. The following BC E2 78 FF E2 0B 8D produces seq_done.
- Force 300 mismatches with ERR_CNT_W=8: err_count holds FF. clear_err together with a mismatch gives err_count=0.
- Assert reset low mid-sequence at exp_index=5: all outputs return to their reset values immediately. After release, a full sequence re-locks.

Source files
------------

// File: rtl/sequence_checker_pkg.sv
// Shared definitions for the sequence generator/checker pair: expected byte table and checker states.
package seq_pkg;
  localparam int SEQ_LEN = 8;
  localparam int IDX_W   = $clog2(SEQ_LEN);

  // Element 0 is the leftmost entry, so SEQ[i] is the i-th transmitted byte.
  localparam logic [0:SEQ_LEN-1][7:0] SEQ = {
    8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
  };

  typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_e;
endpackage

// File: rtl/sequence_checker_if.sv
// Receive link and status bundle of the sequence checker.
// SEQ_CHECKER_STATS_EN adds the done_count statistic.
import seq_pkg::*;

interface sequence_checker_if #(parameter int ERR_CNT_W = 8);
  logic                 data_valid;
  logic [7:0]           data_in;
  logic                 clear_err;
  logic                 locked;
  logic [IDX_W-1:0]     exp_index;
  logic                 seq_done;
  logic                 seq_error;
  logic [ERR_CNT_W-1:0] err_count;
`ifdef SEQ_CHECKER_STATS_EN
  logic [15:0]          done_count;
`endif

  modport master (
    output data_valid, data_in, clear_err,
    input  locked, exp_index, seq_done, seq_error, err_count
`ifdef SEQ_CHECKER_STATS_EN
    , input done_count
`endif
  );

  modport slave (
    input  data_valid, data_in, clear_err,
    output locked, exp_index, seq_done, seq_error, err_count
`ifdef SEQ_CHECKER_STATS_EN
    , output done_count
`endif
  );
endinterface

// File: rtl/sequence_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt_q <= '0;
    else if (clr_i)                  cnt_q <= '0;
    else if (inc_i && cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
  end

  assign count_o = cnt_q;
endmodule

// File: rtl/sequence_checker.sv
// Checks a received byte stream against the fixed 8-byte sequence; reports lock, completions, mismatches.
// SEQ_CHECKER_STATS_EN adds a wrapping 16-bit completed-sequence counter.
import seq_pkg::*;

module sequence_checker #(
  parameter int ERR_CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  sequence_checker_if.slave bus
);
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.data_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.data_in == SEQ[0]) begin
            state_d = TRACK;
            idx_d   = IDX_W'(1);
          end else begin
            idx_d   = '0;
          end
        end
        TRACK: begin
          // Positional compare only: the repeated E2 never triggers a search.
          if (bus.data_in == SEQ[idx_q]) begin
            idx_d  = IDX_W'(idx_q + 1'b1);
            done_d = (idx_q == IDX_W'(SEQ_LEN - 1));
          end else begin
            err_d = 1'b1;
            if (bus.data_in == SEQ[0]) begin
              idx_d = IDX_W'(1);
            end else begin
              state_d = HUNT;
              idx_d   = '0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = '0;
        end
      endcase
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (err_d),
    .clr_i   (bus.clear_err),
    .count_o (bus.err_count)
  );

  assign bus.locked    = (state_q == TRACK);
  assign bus.exp_index = idx_q;
  assign bus.seq_done  = done_q;
  assign bus.seq_error = err_q;

`ifdef SEQ_CHECKER_STATS_EN
  logic [15:0] dcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             dcnt_q <= '0;
    else if (bus.clear_err) dcnt_q <= '0;
    else if (done_d)        dcnt_q <= dcnt_q + 1'b1;
  end

  assign bus.done_count = dcnt_q;
`endif
endmodule
